// File: rtl/jtcop_ba2mcu_port.sv
// Responder for the MCU-to-BAC-06 byte bus: turns HuC6280 byte requests into
// byte-enabled 16-bit cycles on the BAC-06 RAM port and holds the MCU mode bytes.
module jtcop_ba2mcu_port #(
    parameter int unsigned AW     = 11,
    parameter int unsigned TOUT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    // MCU RAM request
    input  logic          mcu_cs,
    input  logic          mcu_rnw,
    input  logic [AW-1:0] mcu_addr,
    input  logic [1:0]    mcu_dsn,
    input  logic [7:0]    mcu_din,
    output logic [7:0]    mcu_dout,
    output logic          mcu_ok,
    // MCU mode register access
    input  logic          mode_cs,
    input  logic [2:0]    mode_addr,
    output logic [7:0]    mode_dout,
    output logic [63:0]   ctrl,
    // BAC-06 RAM port
    output logic          ram_req,
    input  logic          ram_gnt,
    output logic [AW-1:0] ram_addr,
    output logic [1:0]    ram_we,
    output logic [15:0]   ram_din,
    input  logic [15:0]   ram_dout,
    output logic          tout_err
);

    // Last counter value before the count reaches all-ones
    localparam logic [TOUT_W-1:0] CNT_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITG = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       addr_q;
    logic                rnw_q;
    logic [1:0]          dsn_q;
    logic [7:0]          din_q;
    logic [TOUT_W-1:0]   cnt_q;
    logic [7:0]          mcu_dout_q;
    logic                mcu_ok_q;
    logic                ram_req_q;
    logic [AW-1:0]       ram_addr_q;
    logic [1:0]          ram_we_q;
    logic                tout_err_q;
    logic [63:0]         ctrl_q;
    logic                req_changed;

    // A held request whose address/direction/strobes differ starts a new access
    assign req_changed = (mcu_addr != addr_q) || (mcu_rnw != rnw_q) || (mcu_dsn != dsn_q);

    // RAM access FSM with registered bus and MCU outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rnw_q      <= 1'b1;
            dsn_q      <= 2'b11;
            din_q      <= 8'h00;
            cnt_q      <= '0;
            mcu_dout_q <= 8'hff;
            mcu_ok_q   <= 1'b0;
            ram_req_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_we_q   <= 2'b00;
            tout_err_q <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses
            ram_we_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (mcu_cs && !mcu_ok_q) begin
                        addr_q     <= mcu_addr;
                        rnw_q      <= mcu_rnw;
                        dsn_q      <= mcu_dsn;
                        din_q      <= mcu_din;
                        ram_addr_q <= mcu_addr;
                        ram_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= WAITG;
                    end
                end
                WAITG: begin
                    if (ram_gnt) begin
                        if (rnw_q) begin
                            state_q <= READ;
                        end else begin
                            ram_we_q  <= ~dsn_q;
                            ram_req_q <= 1'b0;
                            mcu_ok_q  <= 1'b1;
                            state_q   <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + TOUT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            // Main CPU never released the bus: complete with dummy data
                            tout_err_q <= 1'b1;
                            mcu_dout_q <= 8'hff;
                            ram_req_q  <= 1'b0;
                            mcu_ok_q   <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                READ: begin
                    if (!ram_gnt) begin
                        // Lost the bus while data was in flight: wait and re-read
                        state_q <= WAITG;
                    end else begin
                        mcu_dout_q <= dsn_q[0] ? ram_dout[15:8] : ram_dout[7:0];
                        ram_req_q  <= 1'b0;
                        mcu_ok_q   <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (!mcu_cs || req_changed) begin
                        mcu_ok_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Mode byte writes, independent of the RAM FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (mode_cs && !mcu_rnw) begin
            ctrl_q[{mode_addr, 3'b000} +: 8] <= mcu_din;
        end
    end

    assign mode_dout = ctrl_q[{mode_addr, 3'b000} +: 8];
    assign ctrl      = ctrl_q;
    assign mcu_dout  = mcu_dout_q;
    assign mcu_ok    = mcu_ok_q;
    assign ram_req   = ram_req_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = {din_q, din_q};
    assign tout_err  = tout_err_q;

endmodule

// File: tb/tb_jtcop_ba2mcu_port.sv
// Scoreboard bench for jtcop_ba2mcu_port: a RAM model answers the BAC-06 port,
// stimulus pushes expected completions/writes, monitors pop and compare.
module tb_jtcop_ba2mcu_port;

    localparam int unsigned AW = 11;
    localparam int unsigned TW = 4;

    logic          clk;
    logic          rst;
    logic          mcu_cs;
    logic          mcu_rnw;
    logic [AW-1:0] mcu_addr;
    logic [1:0]    mcu_dsn;
    logic [7:0]    mcu_din;
    logic [7:0]    mcu_dout;
    logic          mcu_ok;
    logic          mode_cs;
    logic [2:0]    mode_addr;
    logic [7:0]    mode_dout;
    logic [63:0]   ctrl;
    logic          ram_req;
    logic          ram_gnt;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_we;
    logic [15:0]   ram_din;
    logic [15:0]   ram_dout;
    logic          tout_err;

    typedef struct {
        int         tag;
        int         issue;
        int         lat;
        bit         chkd;
        logic [7:0] data;
    } ok_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    we;
        logic [15:0]   din;
    } wr_exp_t;

    ok_exp_t okq[$];
    wr_exp_t wrq[$];

    int checks;
    int errors;
    int cyc;

    logic [15:0] mem [0:2047];

    jtcop_ba2mcu_port #(.AW(AW), .TOUT_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mcu_cs    (mcu_cs),
        .mcu_rnw   (mcu_rnw),
        .mcu_addr  (mcu_addr),
        .mcu_dsn   (mcu_dsn),
        .mcu_din   (mcu_din),
        .mcu_dout  (mcu_dout),
        .mcu_ok    (mcu_ok),
        .mode_cs   (mode_cs),
        .mode_addr (mode_addr),
        .mode_dout (mode_dout),
        .ctrl      (ctrl),
        .ram_req   (ram_req),
        .ram_gnt   (ram_gnt),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .tout_err  (tout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BAC-06 RAM model: byte writes, registered read data; preloaded during reset
    always @(posedge clk) begin
        if (rst) begin
            mem[11'h034] <= 16'hbeef;
            mem[11'h412] <= 16'h1234;
            mem[11'h010] <= 16'h1122;
            mem[11'h011] <= 16'h3344;
            mem[11'h020] <= 16'h0000;
        end else begin
            if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int tag, input logic [AW-1:0] a, input logic rnw,
                             input logic [1:0] dsn, input logic [7:0] din,
                             input int lat, input bit chkd, input logic [7:0] d);
        ok_exp_t e;
        e.tag   = tag;
        e.issue = cyc;
        e.lat   = lat;
        e.chkd  = chkd;
        e.data  = d;
        okq.push_back(e);
        mcu_cs   = 1'b1;
        mcu_addr = a;
        mcu_rnw  = rnw;
        mcu_dsn  = dsn;
        mcu_din  = din;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [1:0] we, input logic [15:0] din);
        wr_exp_t w;
        w.addr = a;
        w.we   = we;
        w.din  = din;
        wrq.push_back(w);
    endtask

    task automatic wait_ok(input int tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (mcu_ok) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_ok_%0d: mcu_ok not seen within 100 cycles", tag);
        end
    endtask

    task automatic end_req();
        mcu_cs = 1'b0;
        tick();
    endtask

    // Completion monitor: each rising mcu_ok pops one expected completion
    initial begin
        logic    prev_ok;
        ok_exp_t e;
        prev_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (mcu_ok === 1'b1 && prev_ok !== 1'b1) begin
                if (okq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ok_unexpected: got mcu_ok=1 at cycle %0d expected no completion", cyc);
                end else begin
                    e = okq.pop_front();
                    chk($sformatf("ok_latency_%0d", e.tag), 64'(cyc - e.issue), 64'(e.lat));
                    if (e.chkd) chk($sformatf("rd_data_%0d", e.tag), 64'(mcu_dout), 64'(e.data));
                end
            end
            prev_ok = mcu_ok;
        end
    end

    // RAM write monitor: every cycle with a write enable must match a queued write
    initial begin
        wr_exp_t w;
        forever begin
            @(negedge clk);
            if (ram_we !== 2'b00) begin
                if (wrq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got we=%b addr=%h expected no write", ram_we, ram_addr);
                end else begin
                    w = wrq.pop_front();
                    chk("wr_addr", 64'(ram_addr), 64'(w.addr));
                    chk("wr_we",   64'(ram_we),   64'(w.we));
                    chk("wr_din",  64'(ram_din),  64'(w.din));
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        mcu_cs    = 1'b0;
        mcu_rnw   = 1'b1;
        mcu_addr  = '0;
        mcu_dsn   = 2'b11;
        mcu_din   = 8'h00;
        mode_cs   = 1'b0;
        mode_addr = 3'd0;
        ram_gnt   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_mcu_dout", 64'(mcu_dout), 64'h ff);
        chk("rst_mcu_ok",   64'(mcu_ok),   64'd0);
        chk("rst_ram_req",  64'(ram_req),  64'd0);
        chk("rst_ram_we",   64'(ram_we),   64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ctrl",     ctrl,          64'd0);
        chk("rst_tout_err", 64'(tout_err), 64'd0);

        // Write high-strobe-off byte: low-byte enable only
        push_wr(11'h412, 2'b01, 16'h5a5a);
        start_req(1, 11'h412, 1'b0, 2'b10, 8'h5a, 2, 1'b0, 8'h00);
        wait_ok(1);
        end_req();

        // Reads of 0xbeef by strobe
        start_req(2, 11'h034, 1'b1, 2'b10, 8'h00, 3, 1'b1, 8'hef);
        wait_ok(2); end_req();
        start_req(3, 11'h034, 1'b1, 2'b01, 8'h00, 3, 1'b1, 8'hbe);
        wait_ok(3); end_req();
        start_req(4, 11'h034, 1'b1, 2'b00, 8'h00, 3, 1'b1, 8'hef);
        wait_ok(4); end_req();
        // Earlier write only touched the low byte
        start_req(5, 11'h412, 1'b1, 2'b10, 8'h00, 3, 1'b1, 8'h5a);
        wait_ok(5); end_req();
        start_req(6, 11'h412, 1'b1, 2'b01, 8'h00, 3, 1'b1, 8'h12);
        wait_ok(6); end_req();

        // No-strobe write completes without touching RAM
        start_req(7, 11'h412, 1'b0, 2'b11, 8'h77, 2, 1'b0, 8'h00);
        wait_ok(7); end_req();
        start_req(8, 11'h412, 1'b1, 2'b10, 8'h00, 3, 1'b1, 8'h5a);
        wait_ok(8); end_req();

        // Grant held off 10 cycles
        ram_gnt = 1'b0;
        start_req(9, 11'h034, 1'b1, 2'b10, 8'h00, 12, 1'b1, 8'hef);
        repeat (10) tick();
        chk("wait_ram_req", 64'(ram_req), 64'd1);
        ram_gnt = 1'b1;
        wait_ok(9); end_req();

        // Grant lost during the read cycle forces a re-read
        start_req(10, 11'h034, 1'b1, 2'b01, 8'h00, 5, 1'b1, 8'hbe);
        tick();
        tick();
        ram_gnt = 1'b0;
        tick();
        ram_gnt = 1'b1;
        wait_ok(10); end_req();

        // Back-to-back reads with cs held
        start_req(11, 11'h010, 1'b1, 2'b10, 8'h00, 3, 1'b1, 8'h22);
        wait_ok(11);
        start_req(12, 11'h011, 1'b1, 2'b10, 8'h00, 4, 1'b1, 8'h44);
        wait_ok(12); end_req();

        // Grant stuck low: timeout after 15 waiting cycles
        chk("pre_tout_err", 64'(tout_err), 64'd0);
        ram_gnt = 1'b0;
        start_req(13, 11'h034, 1'b1, 2'b10, 8'h00, 16, 1'b1, 8'hff);
        wait_ok(13); end_req();
        chk("tout_err_set", 64'(tout_err), 64'd1);
        repeat (3) tick();
        chk("tout_err_sticky", 64'(tout_err), 64'd1);
        ram_gnt = 1'b1;

        // Mode register write then read back
        mode_cs   = 1'b1;
        mcu_rnw   = 1'b0;
        mode_addr = 3'd3;
        mcu_din   = 8'h81;
        tick();
        mode_cs = 1'b0;
        chk("mode_dout_3", 64'(mode_dout), 64'h81);
        chk("ctrl_byte3",  ctrl, 64'h0000_0000_8100_0000);
        mode_addr = 3'd2;
        #1;
        chk("mode_dout_2", 64'(mode_dout), 64'h00);

        // RAM write and mode write in the same access
        mode_addr = 3'd5;
        mode_cs   = 1'b1;
        push_wr(11'h020, 2'b11, 16'h3c3c);
        start_req(14, 11'h020, 1'b0, 2'b00, 8'h3c, 2, 1'b0, 8'h00);
        wait_ok(14);
        mode_cs = 1'b0;
        end_req();
        chk("ctrl_byte5", ctrl, 64'h0000_3c00_8100_0000);
        start_req(15, 11'h020, 1'b1, 2'b01, 8'h00, 3, 1'b1, 8'h3c);
        wait_ok(15); end_req();

        // Reset in the middle of a pending write
        ram_gnt  = 1'b0;
        mcu_cs   = 1'b1;
        mcu_rnw  = 1'b0;
        mcu_addr = 11'h030;
        mcu_dsn  = 2'b00;
        mcu_din  = 8'h99;
        repeat (3) tick();
        chk("pre_rst_ram_req", 64'(ram_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ram_req",  64'(ram_req),  64'd0);
        chk("arst_ram_we",   64'(ram_we),   64'd0);
        chk("arst_tout_err", 64'(tout_err), 64'd0);
        chk("arst_ctrl",     ctrl,          64'd0);
        mcu_cs  = 1'b0;
        ram_gnt = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_ok", 64'(mcu_ok), 64'd0);

        // All expected events consumed
        chk("okq_empty", 64'(okq.size()), 64'd0);
        chk("wrq_empty", 64'(wrq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
